slow_frame_receiver: RTL and testbench

- Sits directly downstream of the CDR_10b_8b clock/data recovery stage on the slow link.
- Consumes its decoded byte stream (word tick, 8-bit data, comma flag, code error) and reassembles the 128-bit payload_t frames that SlowTransmitter2 sent.
- Verifies each frame with a checksum byte and presents good frames with a one-cycle valid strobe.
- Tracks link lock and keeps saturating good/bad frame counters for slow-control readback.

---
 rtl/slow_frame_receiver.sv | 205 ++++++++++++++++++++
 tb/tb_slow_frame_receiver.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slow_frame_receiver.sv
// Reassembles 16-byte checksummed frames from the CDR byte stream, tracks link
// lock and keeps saturating good/bad frame counters.
module slow_frame_receiver #(
  parameter int TIMEOUT_CYCLES = 8192,
  parameter int LOCK_GOOD      = 4,
  parameter int UNLOCK_BAD     = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         word_tick_i,
  input  logic [7:0]   data_i,
  input  logic         comma_i,
  input  logic         error_i,
  output logic [127:0] payload_o,
  output logic         frame_valid_o,
  output logic         frame_error_o,
  output logic         locked_o,
  output logic [15:0]  good_count_o,
  output logic [15:0]  bad_count_o
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GS_W = $clog2(LOCK_GOOD + 1);
  localparam int BS_W = $clog2(UNLOCK_BAD + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GS_W-1:0] GS_MAX  = GS_W'(LOCK_GOOD);
  localparam logic [BS_W-1:0] BS_MAX  = BS_W'(UNLOCK_BAD);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [3:0]      count_reg, count_next;
  logic [7:0]      xor_reg, xor_next;
  logic [TO_W-1:0] timeout_reg, timeout_next;
  logic            store_en;
  logic            good_evt;
  logic            bad_evt;
  logic [127:0]    shadow;

  logic [127:0]    payload_reg, payload_next;
  logic            valid_reg, valid_next;
  logic            error_reg, error_next;
  logic            locked_reg, locked_next;
  logic [15:0]     good_count_reg, good_count_next;
  logic [15:0]     bad_count_reg, bad_count_next;
  logic [GS_W-1:0] good_streak_reg, good_streak_next;
  logic [BS_W-1:0] bad_streak_reg, bad_streak_next;

  // ---------------------------------------------------------------- FSM state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= HUNT;
      count_reg   <= '0;
      xor_reg     <= '0;
      timeout_reg <= '0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      xor_reg     <= xor_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    xor_next     = xor_reg;
    timeout_next = timeout_reg;
    store_en     = 1'b0;
    good_evt     = 1'b0;
    bad_evt      = 1'b0;
    case (state_reg)
      DATA, CHECK: begin
        if (word_tick_i) begin
          timeout_next = '0;
          if (error_i) begin
            bad_evt    = 1'b1;
            state_next = HUNT;
          end else if (comma_i) begin
            // A comma inside a frame aborts it and starts the next one.
            bad_evt    = 1'b1;
            state_next = DATA;
            count_next = '0;
            xor_next   = '0;
          end else if (state_reg == DATA) begin
            store_en = 1'b1;
            xor_next = xor_reg ^ data_i;
            if (count_reg == 4'd15) begin
              state_next = CHECK;
            end else begin
              count_next = count_reg + 4'd1;
            end
          end else begin
            if (data_i == xor_reg) begin
              good_evt = 1'b1;
            end else begin
              bad_evt = 1'b1;
            end
            state_next = HUNT;
          end
        end else if (timeout_reg == TO_LAST) begin
          bad_evt      = 1'b1;
          state_next   = HUNT;
          timeout_next = '0;
        end else begin
          timeout_next = timeout_reg + 1'b1;
        end
      end
      default: begin
        timeout_next = '0;
        if (word_tick_i && comma_i && !error_i) begin
          state_next = DATA;
          count_next = '0;
          xor_next   = '0;
        end
      end
    endcase
  end

  // ------------------------------------------------------- frame shadow bytes
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_shadow
      logic [7:0] byte_reg;
      always_ff @(posedge clk) begin
        if (!reset) begin
          byte_reg <= '0;
        end else if (store_en && count_reg == 4'(gi)) begin
          byte_reg <= data_i;
        end
      end
      assign shadow[8*gi +: 8] = byte_reg;
    end
  endgenerate

  // ------------------------------------------------ results, counters, lock
  always_comb begin
    payload_next     = payload_reg;
    valid_next       = good_evt;
    error_next       = bad_evt;
    locked_next      = locked_reg;
    good_count_next  = good_count_reg;
    bad_count_next   = bad_count_reg;
    good_streak_next = good_streak_reg;
    bad_streak_next  = bad_streak_reg;
    if (good_evt) begin
      payload_next = shadow;
      if (good_count_reg != 16'hFFFF) begin
        good_count_next = good_count_reg + 16'd1;
      end
      bad_streak_next = '0;
      if (good_streak_reg != GS_MAX) begin
        good_streak_next = good_streak_reg + 1'b1;
      end
      if (good_streak_next == GS_MAX) begin
        locked_next = 1'b1;
      end
    end else if (bad_evt) begin
      if (bad_count_reg != 16'hFFFF) begin
        bad_count_next = bad_count_reg + 16'd1;
      end
      good_streak_next = '0;
      if (bad_streak_reg != BS_MAX) begin
        bad_streak_next = bad_streak_reg + 1'b1;
      end
      if (bad_streak_next == BS_MAX) begin
        locked_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      payload_reg     <= '0;
      valid_reg       <= 1'b0;
      error_reg       <= 1'b0;
      locked_reg      <= 1'b0;
      good_count_reg  <= '0;
      bad_count_reg   <= '0;
      good_streak_reg <= '0;
      bad_streak_reg  <= '0;
    end else begin
      payload_reg     <= payload_next;
      valid_reg       <= valid_next;
      error_reg       <= error_next;
      locked_reg      <= locked_next;
      good_count_reg  <= good_count_next;
      bad_count_reg   <= bad_count_next;
      good_streak_reg <= good_streak_next;
      bad_streak_reg  <= bad_streak_next;
    end
  end

  assign payload_o     = payload_reg;
  assign frame_valid_o = valid_reg;
  assign frame_error_o = error_reg;
  assign locked_o      = locked_reg;
  assign good_count_o  = good_count_reg;
  assign bad_count_o   = bad_count_reg;

endmodule

// File: tb/tb_slow_frame_receiver.sv
// Bench for slow_frame_receiver: directed scenarios plus random word streams
// checked against a frame-level reference model.
module tb_slow_frame_receiver;

  localparam int TIMEOUT_CYCLES = 8192;
  localparam int LOCK_GOOD      = 4;
  localparam int UNLOCK_BAD     = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         word_tick_i = 1'b0;
  logic [7:0]   data_i = '0;
  logic         comma_i = 1'b0;
  logic         error_i = 1'b0;
  logic [127:0] payload_o;
  logic         frame_valid_o;
  logic         frame_error_o;
  logic         locked_o;
  logic [15:0]  good_count_o;
  logic [15:0]  bad_count_o;

  int checks = 0;
  int failures = 0;

  slow_frame_receiver #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .LOCK_GOOD(LOCK_GOOD),
    .UNLOCK_BAD(UNLOCK_BAD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .word_tick_i(word_tick_i),
    .data_i(data_i),
    .comma_i(comma_i),
    .error_i(error_i),
    .payload_o(payload_o),
    .frame_valid_o(frame_valid_o),
    .frame_error_o(frame_error_o),
    .locked_o(locked_o),
    .good_count_o(good_count_o),
    .bad_count_o(bad_count_o)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------- reference model
  logic [7:0]   m_q[$];
  bit           m_in_frame;
  logic [127:0] m_payload;
  logic [15:0]  m_good, m_bad;
  int           m_gs, m_bs;
  bit           m_locked;
  bit           exp_valid, exp_error;

  typedef struct packed {
    logic       c;
    logic [7:0] d;
    logic       e;
  } word_t;

  function automatic void m_reset();
    m_q.delete();
    m_in_frame = 0;
    m_payload = '0;
    m_good = '0;
    m_bad = '0;
    m_gs = 0;
    m_bs = 0;
    m_locked = 0;
    exp_valid = 0;
    exp_error = 0;
  endfunction

  function automatic void m_good_path(input logic [127:0] p);
    m_payload = p;
    exp_valid = 1;
    if (m_good != 16'hFFFF) m_good = m_good + 16'd1;
    m_bs = 0;
    if (m_gs < LOCK_GOOD) m_gs++;
    if (m_gs == LOCK_GOOD) m_locked = 1;
  endfunction

  function automatic void m_bad_path();
    exp_error = 1;
    if (m_bad != 16'hFFFF) m_bad = m_bad + 16'd1;
    m_gs = 0;
    if (m_bs < UNLOCK_BAD) m_bs++;
    if (m_bs == UNLOCK_BAD) m_locked = 0;
  endfunction

  function automatic void m_tick(input logic c, input logic [7:0] d, input logic e);
    logic [7:0]   x;
    logic [127:0] p;
    x = '0;
    p = '0;
    exp_valid = 0;
    exp_error = 0;
    if (!m_in_frame) begin
      if (c && !e) begin
        m_in_frame = 1;
        m_q.delete();
      end
    end else if (e) begin
      m_bad_path();
      m_in_frame = 0;
    end else if (c) begin
      m_bad_path();
      m_q.delete();
    end else if (m_q.size() < 16) begin
      m_q.push_back(d);
    end else begin
      for (int k = 0; k < 16; k++) begin
        x = x ^ m_q[k];
        p[8*k +: 8] = m_q[k];
      end
      if (x == d) m_good_path(p);
      else m_bad_path();
      m_in_frame = 0;
    end
  endfunction

  function automatic logic [162:0] act_vec();
    return {payload_o, frame_valid_o, frame_error_o, locked_o, good_count_o, bad_count_o};
  endfunction

  function automatic logic [162:0] exp_vec();
    return {m_payload, exp_valid, exp_error, m_locked, m_good, m_bad};
  endfunction

  function automatic logic [7:0] xor16(input logic [127:0] p);
    logic [7:0] x;
    x = '0;
    for (int k = 0; k < 16; k++) x = x ^ p[8*k +: 8];
    return x;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ------------------------------------------------------------- drivers
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      word_tick_i = 1'b0;
      @(posedge clk);
      #1;
      exp_valid = 0;
      exp_error = 0;
    end
  endtask

  task automatic send(input logic c, input logic [7:0] d, input logic e, input int gap);
    idle(gap);
    @(negedge clk);
    word_tick_i = 1'b1;
    comma_i = c;
    data_i = d;
    error_i = e;
    @(posedge clk);
    #1;
    word_tick_i = 1'b0;
    comma_i = 1'b0;
    error_i = 1'b0;
    m_tick(c, d, e);
  endtask

  task automatic send_frame(input logic [127:0] p, input logic [7:0] ck);
    send(1'b1, 8'h00, 1'b0, 0);
    for (int k = 0; k < 16; k++) send(1'b0, p[8*k +: 8], 1'b0, 0);
    send(1'b0, ck, 1'b0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    word_tick_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    m_reset();
  endtask

  // --------------------------------------------------------------- tests
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    m_reset();
    checks++;
    if (act_vec() !== 163'd0) begin
      failures++;
      $display("FAIL reset_state got=%h want=0", act_vec());
    end
    reset = 1'b1;
    idle(2);
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL reset_idle got=%h want=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_clean_frame();
    logic [127:0] p;
    logic [127:0] want;
    want = 128'h100F0E0D0C0B0A090807060504030201;
    for (int k = 0; k < 16; k++) p[8*k +: 8] = 8'(k + 1);
    send_frame(p, 8'h10);
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL clean_model got=%h want=%h", act_vec(), exp_vec());
    end
    checks++;
    if ({payload_o, frame_valid_o, frame_error_o, good_count_o, locked_o} !== {want, 1'b1, 1'b0, 16'd1, 1'b0}) begin
      failures++;
      $display("FAIL clean_const payload=%h valid=%b err=%b good=%0d locked=%b want payload=%h valid=1 err=0 good=1 locked=0",
               payload_o, frame_valid_o, frame_error_o, good_count_o, locked_o, want);
    end
    idle(1);
    checks++;
    if (frame_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL clean_pulse_width valid=%b want 0", frame_valid_o);
    end
  endtask

  task automatic test_lock_unlock();
    logic [127:0] p;
    logic [127:0] last_good;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      p = rand128();
      send_frame(p, xor16(p));
      last_good = p;
      checks++;
      if (act_vec() !== exp_vec() || locked_o !== (i == 3)) begin
        failures++;
        $display("FAIL lock_frame%0d got=%h want=%h locked=%b", i, act_vec(), exp_vec(), locked_o);
      end
    end
    for (int k = 0; k < 16; k++) p[8*k +: 8] = 8'(k + 1);
    for (int i = 0; i < 2; i++) begin
      send_frame(p, 8'h11);
      checks++;
      if (act_vec() !== exp_vec() || locked_o !== (i == 0) || bad_count_o !== 16'(i + 1)
          || payload_o !== last_good) begin
        failures++;
        $display("FAIL unlock_bad%0d got=%h want=%h locked=%b bad=%0d", i, act_vec(), exp_vec(),
                 locked_o, bad_count_o);
      end
    end
  endtask

  task automatic test_mid_comma();
    logic [127:0] aa;
    aa = {16{8'hAA}};
    send(1'b1, 8'h00, 1'b0, 0);
    for (int k = 0; k < 5; k++) send(1'b0, 8'($urandom), 1'b0, 0);
    send(1'b1, 8'h00, 1'b0, 0);
    checks++;
    if (act_vec() !== exp_vec() || frame_error_o !== 1'b1 || frame_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_comma_abort got=%h want=%h", act_vec(), exp_vec());
    end
    for (int k = 0; k < 16; k++) send(1'b0, 8'hAA, 1'b0, 0);
    send(1'b0, 8'h00, 1'b0, 0);
    checks++;
    if (act_vec() !== exp_vec() || payload_o !== aa || frame_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_comma_restart got=%h want=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_code_error();
    logic [127:0] p;
    p = rand128();
    send(1'b1, 8'h00, 1'b0, 0);
    for (int k = 0; k < 7; k++) send(1'b0, p[8*k +: 8], 1'b0, 0);
    send(1'b0, p[63:56], 1'b1, 0);
    checks++;
    if (act_vec() !== exp_vec() || frame_error_o !== 1'b1) begin
      failures++;
      $display("FAIL code_error_abort got=%h want=%h", act_vec(), exp_vec());
    end
    for (int k = 8; k < 16; k++) send(1'b0, p[8*k +: 8], 1'b0, 1);
    send(1'b0, xor16(p), 1'b0, 0);
    checks++;
    if (act_vec() !== exp_vec() || frame_error_o !== 1'b0 || frame_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL code_error_hunt got=%h want=%h", act_vec(), exp_vec());
    end
    p = rand128();
    send_frame(p, xor16(p));
    checks++;
    if (act_vec() !== exp_vec() || payload_o !== p) begin
      failures++;
      $display("FAIL code_error_recover got=%h want=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_timeout();
    int nerr;
    int first_idx;
    nerr = 0;
    first_idx = -1;
    send(1'b1, 8'h00, 1'b0, 0);
    for (int k = 0; k < 4; k++) send(1'b0, 8'($urandom), 1'b0, 0);
    for (int i = 1; i <= TIMEOUT_CYCLES + 20; i++) begin
      @(posedge clk);
      #1;
      if (frame_error_o === 1'b1) begin
        nerr++;
        if (first_idx < 0) first_idx = i;
      end
    end
    m_bad_path();
    m_in_frame = 0;
    exp_valid = 0;
    exp_error = 0;
    checks++;
    if (nerr != 1 || first_idx < TIMEOUT_CYCLES - 1 || first_idx > TIMEOUT_CYCLES + 1) begin
      failures++;
      $display("FAIL timeout_pulse count=%0d at_cycle=%0d want count=1 at_cycle=%0d", nerr, first_idx,
               TIMEOUT_CYCLES);
    end
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL timeout_state got=%h want=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    word_t        stim[$];
    word_t        w;
    logic [127:0] p;
    int           kind;
    int           pos;
    for (int f = 0; f < 60; f++) begin
      kind = $urandom_range(0, 5);
      p = rand128();
      pos = $urandom_range(0, 16);
      if (kind == 5) begin
        repeat ($urandom_range(1, 4)) begin
          w.c = 1'($urandom_range(0, 3) == 0);
          w.e = 1'($urandom_range(0, 2) == 0);
          w.d = 8'($urandom);
          stim.push_back(w);
        end
      end else begin
        w = '{c: 1'b1, d: 8'h00, e: 1'b0};
        stim.push_back(w);
        for (int k = 0; k < 17; k++) begin
          w.c = 1'b0;
          w.e = 1'b0;
          w.d = (k < 16) ? p[8*k +: 8] : xor16(p) ^ ((kind == 2) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
          if (kind == 3 && k == pos) w.e = 1'b1;
          if (kind == 4 && k == pos) w.c = 1'b1;
          stim.push_back(w);
        end
      end
    end
    foreach (stim[i]) begin
      send(stim[i].c, stim[i].d, stim[i].e, $urandom_range(0, 2));
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random_tick%0d c=%b e=%b d=%h got=%h want=%h", i, stim[i].c, stim[i].e, stim[i].d,
                 act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_saturation();
    logic [127:0] p;
    do_reset();
    @(negedge clk);
    force dut.good_count_reg = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.good_count_reg;
    m_good = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      p = rand128();
      send_frame(p, xor16(p));
      checks++;
      if (act_vec() !== exp_vec() || good_count_o !== 16'hFFFF) begin
        failures++;
        $display("FAIL saturation%0d good=%h want=ffff got=%h model=%h", i, good_count_o, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [127:0] p;
    p = rand128();
    send(1'b1, 8'h00, 1'b0, 0);
    for (int k = 0; k < 5; k++) send(1'b0, p[8*k +: 8], 1'b0, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    m_reset();
    checks++;
    if (act_vec() !== 163'd0) begin
      failures++;
      $display("FAIL reset_midframe got=%h want=0", act_vec());
    end
    reset = 1'b1;
    for (int k = 5; k < 16; k++) send(1'b0, p[8*k +: 8], 1'b0, 0);
    send(1'b0, xor16(p), 1'b0, 0);
    checks++;
    if (act_vec() !== exp_vec() || frame_valid_o !== 1'b0 || frame_error_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_discard got=%h want=%h", act_vec(), exp_vec());
    end
    p = rand128();
    send_frame(p, xor16(p));
    checks++;
    if (act_vec() !== exp_vec() || payload_o !== p || good_count_o !== 16'd1) begin
      failures++;
      $display("FAIL reset_recover got=%h want=%h", act_vec(), exp_vec());
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_clean_frame();
    test_lock_unlock();
    test_mid_comma();
    test_code_error();
    test_timeout();
    test_random();
    test_saturation();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
